// File: rtl/keccak_pkg.sv
// Shared constants, ingress state encoding and index helpers for the
// Keccak block-streaming ingress and the padders built on it.
package keccak_pkg;

  localparam int WORD_W     = 32;
  localparam int RATE_WORDS = 18;
  localparam int RATE_BITS  = WORD_W * RATE_WORDS;
  localparam int RATE_BYTES = RATE_BITS / 8;
  localparam int CNT_W      = 5;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  // Stand-alone pad block used when the message ends exactly on a rate boundary.
  localparam logic [RATE_BITS-1:0] PAD_ONLY_BLOCK =
    {PAD_FINAL, {(RATE_BITS-16){1'b0}}, PAD_DOMAIN};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HANDOFF,
    ST_PADBLK
  } ingress_state_t;

  // Bit offset of word idx inside the rate buffer.
  function automatic int word_lsb(input logic [CNT_W-1:0] idx);
    return WORD_W * int'(idx);
  endfunction

  // Bit offset of byte idx inside the rate buffer.
  function automatic int byte_lsb(input int byte_idx);
    return 8 * byte_idx;
  endfunction

  // Block length requested by the controller; 0 or anything past a full
  // rate block means "a whole rate block".
  function automatic logic [CNT_W-1:0] clamp_target(input logic [5:0] req);
    if (req == 6'd0 || int'(req) > RATE_WORDS) begin
      return CNT_W'(RATE_WORDS);
    end
    return req[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/keccak_pad_gen.sv
// Combinational SHA3 padder: applies domain/final pad bytes after n whole
// words, or flags that a separate pad block is required when the data
// fills the whole rate.
module keccak_pad_gen
  import keccak_pkg::*;
(
  input  logic [RATE_BITS-1:0] block_in,
  input  logic [CNT_W-1:0]     word_count,
  input  logic                 last,
  output logic [RATE_BITS-1:0] block_out,
  output logic                 need_extra_block
);

  // Pad in place when there is room, otherwise defer the pad to a new block.
  always_comb begin
    block_out        = block_in;
    need_extra_block = 1'b0;
    if (last) begin
      if (int'(word_count) < RATE_WORDS) begin
        block_out[byte_lsb(int'(word_count) * (WORD_W / 8)) +: 8] =
          block_out[byte_lsb(int'(word_count) * (WORD_W / 8)) +: 8] ^ PAD_DOMAIN;
        block_out[byte_lsb(RATE_BYTES - 1) +: 8] =
          block_out[byte_lsb(RATE_BYTES - 1) +: 8] ^ PAD_FINAL;
      end else begin
        need_extra_block = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keccak_block_ingress.sv
// Receiving end of the 32-bit block stream into keccak_top: packs words
// LSB-first into the rate buffer, pads the final message block, and hands
// completed blocks to the permutation core over a valid/ready port.
module keccak_block_ingress
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sha_init,
  input  logic                 mode_block,
  input  logic                 start_block,
  input  logic [5:0]           words_in_block,
  input  logic [WORD_W-1:0]    block_word,
  input  logic                 block_word_valid,
  input  logic                 block_last,
  output logic                 sha_busy,
  output logic                 sha_buffer_full,
  output logic [RATE_BITS-1:0] absorb_block,
  output logic                 absorb_valid,
  output logic                 absorb_last,
  input  logic                 absorb_ready,
  output logic                 proto_err
);

  ingress_state_t       state;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     target;
  logic [RATE_BITS-1:0] fill_buf;
  logic                 pad_pending;

  logic                 word_accept;
  logic [CNT_W-1:0]     count_next;
  logic [RATE_BITS-1:0] buf_with_word;
  logic [RATE_BITS-1:0] padded_block;
  logic                 need_extra;
  logic                 close_block;
  logic                 early_last;
  logic                 short_fill;

  // Next buffer image and block-closing conditions for the word on the bus.
  always_comb begin
    word_accept   = (state == ST_FILL) && block_word_valid && !sha_buffer_full;
    count_next    = count + CNT_W'(1);
    buf_with_word = fill_buf;
    if (int'(count) < RATE_WORDS) begin
      buf_with_word[word_lsb(count) +: WORD_W] = block_word;
    end
    close_block = (count_next == target) || block_last;
    early_last  = block_last && (count_next != target);
    short_fill  = !block_last && (count_next == target) &&
                  (int'(target) < RATE_WORDS);
  end

  keccak_pad_gen u_pad_gen (
    .block_in         (buf_with_word),
    .word_count       (count_next),
    .last             (block_last),
    .block_out        (padded_block),
    .need_extra_block (need_extra)
  );

  // Ingress FSM with registered handshake and back-pressure outputs.
  always_ff @(posedge clk) begin
    if (reset || sha_init) begin
      state           <= ST_IDLE;
      count           <= '0;
      target          <= '0;
      fill_buf        <= '0;
      pad_pending     <= 1'b0;
      sha_busy        <= 1'b0;
      sha_buffer_full <= 1'b0;
      absorb_block    <= '0;
      absorb_valid    <= 1'b0;
      absorb_last     <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_block && mode_block) begin
            state           <= ST_FILL;
            target          <= clamp_target(words_in_block);
            count           <= '0;
            fill_buf        <= '0;
            pad_pending     <= 1'b0;
            sha_busy        <= 1'b1;
            sha_buffer_full <= 1'b0;
          end
        end
        ST_FILL: begin
          if (word_accept) begin
            count    <= count_next;
            fill_buf <= buf_with_word;
            if (close_block) begin
              absorb_block    <= padded_block;
              absorb_valid    <= 1'b1;
              absorb_last     <= block_last && !need_extra;
              pad_pending     <= need_extra;
              sha_buffer_full <= 1'b1;
              state           <= ST_HANDOFF;
              if (early_last || short_fill) begin
                proto_err <= 1'b1;
              end
            end
          end
        end
        ST_HANDOFF: begin
          if (absorb_ready) begin
            if (pad_pending) begin
              absorb_block <= PAD_ONLY_BLOCK;
              absorb_last  <= 1'b1;
              pad_pending  <= 1'b0;
              state        <= ST_PADBLK;
            end else begin
              absorb_valid    <= 1'b0;
              absorb_last     <= 1'b0;
              sha_busy        <= 1'b0;
              sha_buffer_full <= 1'b0;
              state           <= ST_IDLE;
            end
          end
        end
        ST_PADBLK: begin
          if (absorb_ready) begin
            absorb_valid    <= 1'b0;
            absorb_last     <= 1'b0;
            sha_busy        <= 1'b0;
            sha_buffer_full <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
